tracer_sched: RTL and testbench
===============================

Name: tracer_sched

Overview:
- Slot scheduler for the instruction trace table: 2^ABITS step slots in a ring.
- Allocates a slot per executed instruction and tracks its memory operations.
- Marks the step completed once the instruction is closed and all its memops have finished.
- Drains completed steps strictly in program order to the trace writer.
- Owns only indices, flags and counters. Step payloads (pc, instr, reg/mem actions) live in the trace storage, addressed by the indices this block issues.

Parameters:
- ABITS, 6, slot index width; table depth SZ = 2^ABITS.
- MCNT_BITS, 4, width of the per-slot pending-memop counter.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_open_valid  in  1  executor opens a new step.
- o_open_ready  out  1  a free slot exists (total < SZ).
- o_open_idx  out  ABITS  slot index granted (= wcnt).
- i_mreq_valid  in  1  memop issued for a step.
- i_mreq_idx  in  ABITS  slot of the issued memop.
- i_mcmpl_valid  in  1  memop completed.
- i_mcmpl_idx  in  ABITS  slot of the completed memop.
- i_close_valid  in  1  step will issue no further actions.
- i_close_idx  in  ABITS  slot being closed.
- i_flush  in  1  discard all slots (pipeline flush or trace restart).
- o_retire_valid  out  1  step at rcnt is completed.
- o_retire_idx  out  ABITS  = rcnt.
- i_retire_ready  in  1  trace writer accepts the step.
- o_total  out  ABITS+1  occupied slot count, 0..SZ.
- o_opened  out  ABITS  index of the most recently opened slot.
- o_err  out  1  sticky protocol-error flag.

Behaviour:
- Per-slot state: FREE, OPEN, CLOSED, DONE, plus pending counter pcnt[MCNT_BITS].
- Transitions:
  - FREE->OPEN on accepted open (pcnt=0).
  - OPEN->CLOSED on close when pcnt>0 after this cycle's updates.
  - OPEN->DONE on close when pcnt=0 after this cycle's updates.
  - CLOSED->DONE when pcnt reaches 0.
  - DONE->FREE on retire handshake.
- Open accepted when i_open_valid & o_open_ready.
  - o_open_ready is combinational from the registered total; a same-cycle retire does not free space for that cycle's open.
  - On accept: wcnt+1 (wraps modulo SZ), opened<=wcnt.
- Memop issue and completion on the same slot in the same cycle: pcnt unchanged.
  - Issue at pcnt = 2^MCNT_BITS-1: o_err<=1, pcnt unchanged.
- Completion with pcnt=0, or to a FREE/DONE slot: o_err<=1, ignored.
- Memop issue to a slot not OPEN: o_err<=1, ignored.
- Close to a slot not OPEN: o_err<=1, ignored.
- A close may coincide with the final completion; the slot goes directly to DONE.
- Retire:
  - o_retire_valid = (state[rcnt]==DONE), combinational from registered state.
  - Handshake is valid & ready; on handshake rcnt+1 (wraps) and the slot is freed.
  - Retire occurs at most once per cycle and strictly in order: DONE slots behind a non-DONE rcnt wait.
- Latency: close sampled at edge N with pcnt=0 gives o_retire_valid high in cycle N+1, provided that slot is at rcnt.
- total = total + open_accept - retire_hs; open and retire in the same cycle leave total unchanged.
- Flush (synchronous, highest priority): all slots FREE, pcnt=0, wcnt=rcnt=total=opened=0. o_err is kept. Open/retire in the flush cycle are ignored.
- Reset values:
  - all slots FREE, pcnt=0;
  - wcnt=rcnt=0, total=0, opened=0, o_err=0;
  - outputs o_open_ready=1, o_open_idx=0, o_retire_valid=0, o_retire_idx=0, o_total=0, o_opened=0.
- Reset asserted mid-operation forces these values immediately.
- Full: total=SZ gives o_open_ready=0. Empty: total=0 gives o_retire_valid=0.

Decomposition:
- Package additions:
  - slot state enum: FREE/OPEN/CLOSED/DONE;
  - localparams TRACE_TBL_ABITS/SZ reused as the ABITS/SZ defaults;
  - struct TraceSlotType {state, pcnt}.
- One natural sub-module: tracer_slot.
  - Holds a single slot's state and pcnt.
  - Inputs: decoded open/mreq/mcmpl/close/retire/flush strobes.
  - Outputs: state and per-slot error.
  - Instantiated SZ times via generate.
- Top level keeps wcnt/rcnt/total/opened, decode and error OR.

Test Plan:
- Reset, then 3 opens with no memops, each closed the next cycle, ready=1 → idx 0,1,2 granted; retire_valid with idx 0,1,2 in consecutive cycles; total returns to 0.
- Open slot 0, issue 2 memops, close, complete both in separate cycles → CLOSED until the 2nd completion; retire_valid exactly 1 cycle after the 2nd completion.
- Open slots 0,1; close 1 first, then close 0 two cycles later → no retire until slot 0 is DONE; then idx 0 and idx 1 retire in order.
- 64 opens with none retired → o_open_ready=0, total=64. The 65th open is ignored (wcnt stays 0). Retire with ready held at 0 for 5 cycles keeps valid=1 and idx=0.
- Same-cycle memop issue and completion on slot 3 with pcnt=1 → pcnt stays 1. Completion to a FREE slot → o_err=1 and stays set.
- Flush with total=10, or assert i_rst mid-sequence → total=0, all indices 0, retire_valid=0. Flush keeps o_err set; reset clears it.

Source files
------------

// File: rtl/tracer_sched_pkg.sv
// Shared types and defaults for the instruction-trace slot scheduler.
package tracer_sched_pkg;

    localparam int unsigned TRACE_TBL_ABITS = 6;
    localparam int unsigned TRACE_TBL_SZ    = 1 << TRACE_TBL_ABITS;
    localparam int unsigned TRACE_MCNT_BITS = 4;

    typedef enum logic [1:0] {
        SLOT_FREE,
        SLOT_OPEN,
        SLOT_CLOSED,
        SLOT_DONE
    } slot_state_t;

    typedef struct packed {
        slot_state_t                state;
        logic [TRACE_MCNT_BITS-1:0] pcnt;
    } TraceSlotType;

endpackage

// File: rtl/tracer_slot.sv
// One trace-table slot: lifecycle state plus pending-memop counter.
module tracer_slot
    import tracer_sched_pkg::*;
#(
    parameter int unsigned MCNT_BITS = TRACE_MCNT_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        open_req,
    input  logic        mreq,
    input  logic        mcmpl,
    input  logic        close_req,
    input  logic        retire,
    input  logic        flush,
    output slot_state_t state,
    output logic        err
);

    localparam logic [MCNT_BITS-1:0] PMAX = '1;

    slot_state_t          state_q, state_d;
    logic [MCNT_BITS-1:0] pcnt_q, pcnt_d;
    logic                 live, mreq_ok, mcmpl_ok;

    always_comb begin
        state_d  = state_q;
        pcnt_d   = pcnt_q;
        err      = 1'b0;
        live     = (state_q == SLOT_OPEN) || (state_q == SLOT_CLOSED);
        mreq_ok  = mreq && (state_q == SLOT_OPEN);
        mcmpl_ok = mcmpl && live && (pcnt_q != '0);

        if (mreq && !mreq_ok) err = 1'b1;
        if (mcmpl && !mcmpl_ok) err = 1'b1;
        if (close_req && state_q != SLOT_OPEN) err = 1'b1;

        // A matched issue+completion cancels out and cannot overflow.
        if (mreq_ok && !mcmpl_ok) begin
            if (pcnt_q == PMAX) err = 1'b1;
            else pcnt_d = pcnt_q + MCNT_BITS'(1);
        end else if (mcmpl_ok && !mreq_ok) begin
            pcnt_d = pcnt_q - MCNT_BITS'(1);
        end

        unique case (state_q)
            SLOT_FREE: begin
                if (open_req) begin
                    state_d = SLOT_OPEN;
                    pcnt_d  = '0;
                end
            end
            SLOT_OPEN: begin
                if (close_req) state_d = (pcnt_d == '0) ? SLOT_DONE : SLOT_CLOSED;
            end
            SLOT_CLOSED: begin
                if (pcnt_d == '0) state_d = SLOT_DONE;
            end
            SLOT_DONE: begin
                if (retire) state_d = SLOT_FREE;
            end
            default: state_d = SLOT_FREE;
        endcase

        if (flush) begin
            state_d = SLOT_FREE;
            pcnt_d  = '0;
            err     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SLOT_FREE;
            pcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/tracer_sched.sv
// Ring scheduler for trace-table slots: issues indices, tracks completion, retires in order.
module tracer_sched
    import tracer_sched_pkg::*;
#(
    parameter int unsigned ABITS     = TRACE_TBL_ABITS,
    parameter int unsigned MCNT_BITS = TRACE_MCNT_BITS
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_open_valid,
    output logic             o_open_ready,
    output logic [ABITS-1:0] o_open_idx,
    input  logic             i_mreq_valid,
    input  logic [ABITS-1:0] i_mreq_idx,
    input  logic             i_mcmpl_valid,
    input  logic [ABITS-1:0] i_mcmpl_idx,
    input  logic             i_close_valid,
    input  logic [ABITS-1:0] i_close_idx,
    input  logic             i_flush,
    output logic             o_retire_valid,
    output logic [ABITS-1:0] o_retire_idx,
    input  logic             i_retire_ready,
    output logic [ABITS:0]   o_total,
    output logic [ABITS-1:0] o_opened,
    output logic             o_err
);

    localparam int unsigned    SZ   = 1 << ABITS;
    localparam logic [ABITS:0] FULL = (ABITS+1)'(SZ);

    logic [ABITS-1:0] wcnt, rcnt, opened;
    logic [ABITS:0]   total;
    logic             err;
    logic             open_acc, retire_hs;

    slot_state_t      st [SZ];
    logic [SZ-1:0]    open_v, mreq_v, mcmpl_v, close_v, retire_v, slot_err;

    assign o_open_ready   = (total != FULL);
    assign o_retire_valid = (st[rcnt] == SLOT_DONE);
    assign open_acc       = i_open_valid && o_open_ready && !i_flush;
    assign retire_hs      = o_retire_valid && i_retire_ready && !i_flush;

    always_comb begin
        open_v   = '0;
        mreq_v   = '0;
        mcmpl_v  = '0;
        close_v  = '0;
        retire_v = '0;
        for (int unsigned i = 0; i < SZ; i++) begin
            open_v[i]   = open_acc && (wcnt == ABITS'(i));
            mreq_v[i]   = i_mreq_valid && (i_mreq_idx == ABITS'(i));
            mcmpl_v[i]  = i_mcmpl_valid && (i_mcmpl_idx == ABITS'(i));
            close_v[i]  = i_close_valid && (i_close_idx == ABITS'(i));
            retire_v[i] = retire_hs && (rcnt == ABITS'(i));
        end
    end

    for (genvar g = 0; g < SZ; g++) begin : g_slot
        tracer_slot #(
            .MCNT_BITS(MCNT_BITS)
        ) u_slot (
            .clk      (i_clk),
            .rst      (i_rst),
            .open_req (open_v[g]),
            .mreq     (mreq_v[g]),
            .mcmpl    (mcmpl_v[g]),
            .close_req(close_v[g]),
            .retire   (retire_v[g]),
            .flush    (i_flush),
            .state    (st[g]),
            .err      (slot_err[g])
        );
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wcnt   <= '0;
            rcnt   <= '0;
            total  <= '0;
            opened <= '0;
            err    <= 1'b0;
        end else if (i_flush) begin
            wcnt   <= '0;
            rcnt   <= '0;
            total  <= '0;
            opened <= '0;
        end else begin
            if (open_acc) begin
                wcnt   <= wcnt + ABITS'(1);
                opened <= wcnt;
            end
            if (retire_hs) rcnt <= rcnt + ABITS'(1);
            if (open_acc && !retire_hs) total <= total + (ABITS+1)'(1);
            else if (retire_hs && !open_acc) total <= total - (ABITS+1)'(1);
            err <= err | (|slot_err);
        end
    end

    assign o_open_idx   = wcnt;
    assign o_retire_idx = rcnt;
    assign o_total      = total;
    assign o_opened     = opened;
    assign o_err        = err;

endmodule

// File: tb/tb_tracer_sched.sv
// Directed bench for tracer_sched with hand-computed expectations.
module tb_tracer_sched;

    logic       i_clk;
    logic       i_rst;
    logic       i_open_valid;
    logic       o_open_ready;
    logic [5:0] o_open_idx;
    logic       i_mreq_valid;
    logic [5:0] i_mreq_idx;
    logic       i_mcmpl_valid;
    logic [5:0] i_mcmpl_idx;
    logic       i_close_valid;
    logic [5:0] i_close_idx;
    logic       i_flush;
    logic       o_retire_valid;
    logic [5:0] o_retire_idx;
    logic       i_retire_ready;
    logic [6:0] o_total;
    logic [5:0] o_opened;
    logic       o_err;

    int n_cmp  = 0;
    int n_fail = 0;

    tracer_sched #(
        .ABITS(6),
        .MCNT_BITS(4)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_open_valid  (i_open_valid),
        .o_open_ready  (o_open_ready),
        .o_open_idx    (o_open_idx),
        .i_mreq_valid  (i_mreq_valid),
        .i_mreq_idx    (i_mreq_idx),
        .i_mcmpl_valid (i_mcmpl_valid),
        .i_mcmpl_idx   (i_mcmpl_idx),
        .i_close_valid (i_close_valid),
        .i_close_idx   (i_close_idx),
        .i_flush       (i_flush),
        .o_retire_valid(o_retire_valid),
        .o_retire_idx  (o_retire_idx),
        .i_retire_ready(i_retire_ready),
        .o_total       (o_total),
        .o_opened      (o_opened),
        .o_err         (o_err)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic close_slot(input logic [5:0] idx);
        i_close_valid = 1'b1;
        i_close_idx   = idx;
    endtask

    initial begin
        i_rst          = 1'b1;
        i_open_valid   = 1'b0;
        i_mreq_valid   = 1'b0;
        i_mreq_idx     = '0;
        i_mcmpl_valid  = 1'b0;
        i_mcmpl_idx    = '0;
        i_close_valid  = 1'b0;
        i_close_idx    = '0;
        i_flush        = 1'b0;
        i_retire_ready = 1'b0;

        #12;
        chk("rst_ready", o_open_ready, 1);
        chk("rst_open_idx", o_open_idx, 0);
        chk("rst_retire_valid", o_retire_valid, 0);
        chk("rst_retire_idx", o_retire_idx, 0);
        chk("rst_total", o_total, 0);
        chk("rst_opened", o_opened, 0);
        chk("rst_err", o_err, 0);
        i_rst = 1'b0;

        // three opens, each closed one cycle later, retired back to back
        i_open_valid = 1'b1;
        tick();
        chk("t1_total_a", o_total, 1);
        chk("t1_opened_a", o_opened, 0);
        chk("t1_open_idx_a", o_open_idx, 1);
        close_slot(0);
        tick();
        chk("t1_rv_0", o_retire_valid, 1);
        chk("t1_ridx_0", o_retire_idx, 0);
        chk("t1_total_b", o_total, 2);
        chk("t1_opened_b", o_opened, 1);
        i_retire_ready = 1'b1;
        close_slot(1);
        tick();
        chk("t1_total_open_and_retire", o_total, 2);
        chk("t1_rv_1", o_retire_valid, 1);
        chk("t1_ridx_1", o_retire_idx, 1);
        chk("t1_opened_c", o_opened, 2);
        i_open_valid = 1'b0;
        close_slot(2);
        tick();
        chk("t1_rv_2", o_retire_valid, 1);
        chk("t1_ridx_2", o_retire_idx, 2);
        chk("t1_total_d", o_total, 1);
        i_close_valid = 1'b0;
        tick();
        chk("t1_total_end", o_total, 0);
        chk("t1_rv_end", o_retire_valid, 0);
        chk("t1_open_idx_end", o_open_idx, 3);
        i_retire_ready = 1'b0;

        // two memops, close, completions in separate cycles
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        chk("fl1_total", o_total, 0);
        chk("fl1_open_idx", o_open_idx, 0);
        chk("fl1_retire_idx", o_retire_idx, 0);
        i_open_valid = 1'b1;
        tick();
        i_open_valid = 1'b0;
        i_mreq_valid = 1'b1;
        i_mreq_idx   = 6'd0;
        tick();
        tick();
        i_mreq_valid = 1'b0;
        close_slot(0);
        tick();
        i_close_valid = 1'b0;
        chk("t2_closed_rv", o_retire_valid, 0);
        i_mcmpl_valid = 1'b1;
        i_mcmpl_idx   = 6'd0;
        tick();
        chk("t2_one_left_rv", o_retire_valid, 0);
        tick();
        i_mcmpl_valid = 1'b0;
        chk("t2_done_rv", o_retire_valid, 1);
        chk("t2_done_ridx", o_retire_idx, 0);
        i_retire_ready = 1'b1;
        tick();
        i_retire_ready = 1'b0;
        chk("t2_total", o_total, 0);
        chk("t2_rv_after", o_retire_valid, 0);
        chk("t2_err", o_err, 0);

        // out-of-order close must not retire ahead of slot 0
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        i_open_valid = 1'b1;
        tick();
        tick();
        i_open_valid = 1'b0;
        close_slot(1);
        tick();
        i_close_valid = 1'b0;
        chk("t3_wait_a", o_retire_valid, 0);
        tick();
        chk("t3_wait_b", o_retire_valid, 0);
        close_slot(0);
        tick();
        i_close_valid = 1'b0;
        chk("t3_rv0", o_retire_valid, 1);
        chk("t3_ridx0", o_retire_idx, 0);
        i_retire_ready = 1'b1;
        tick();
        chk("t3_rv1", o_retire_valid, 1);
        chk("t3_ridx1", o_retire_idx, 1);
        chk("t3_total1", o_total, 1);
        tick();
        chk("t3_rv_end", o_retire_valid, 0);
        chk("t3_total_end", o_total, 0);
        i_retire_ready = 1'b0;

        // slot 3: issue+completion in the same cycle keeps pcnt at 1
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        i_open_valid = 1'b1;
        repeat (4) tick();
        i_open_valid   = 1'b0;
        i_retire_ready = 1'b1;
        close_slot(0);
        tick();
        close_slot(1);
        tick();
        close_slot(2);
        tick();
        i_close_valid = 1'b0;
        tick();
        i_retire_ready = 1'b0;
        chk("t5_ridx3", o_retire_idx, 3);
        chk("t5_total1", o_total, 1);
        chk("t5_rv_open", o_retire_valid, 0);
        i_mreq_valid = 1'b1;
        i_mreq_idx   = 6'd3;
        tick();
        i_mcmpl_valid = 1'b1;
        i_mcmpl_idx   = 6'd3;
        tick();
        i_mreq_valid  = 1'b0;
        i_mcmpl_valid = 1'b0;
        close_slot(3);
        tick();
        i_close_valid = 1'b0;
        chk("t5_pcnt1_closed", o_retire_valid, 0);
        i_mcmpl_valid = 1'b1;
        tick();
        i_mcmpl_valid = 1'b0;
        chk("t5_done_rv", o_retire_valid, 1);
        chk("t5_done_ridx", o_retire_idx, 3);
        chk("t5_err_clean", o_err, 0);
        i_retire_ready = 1'b1;
        tick();
        i_retire_ready = 1'b0;
        chk("t5_total0", o_total, 0);
        i_mcmpl_valid = 1'b1;
        i_mcmpl_idx   = 6'd5;
        tick();
        i_mcmpl_valid = 1'b0;
        chk("t5_err_set", o_err, 1);
        tick();
        chk("t5_err_sticky", o_err, 1);

        // fill the ring
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        chk("t4_flush_keeps_err", o_err, 1);
        chk("t4_total0", o_total, 0);
        i_open_valid = 1'b1;
        repeat (64) tick();
        chk("t4_full_total", o_total, 64);
        chk("t4_full_ready", o_open_ready, 0);
        chk("t4_full_opened", o_opened, 63);
        chk("t4_full_open_idx", o_open_idx, 0);
        tick();
        i_open_valid = 1'b0;
        chk("t4_65th_total", o_total, 64);
        chk("t4_65th_opened", o_opened, 63);
        chk("t4_65th_open_idx", o_open_idx, 0);
        close_slot(0);
        tick();
        i_close_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_hold_rv", o_retire_valid, 1);
            chk("t4_hold_ridx", o_retire_idx, 0);
        end
        chk("t4_hold_total", o_total, 64);

        // flush with ten occupied slots
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        i_open_valid = 1'b1;
        repeat (10) tick();
        i_open_valid = 1'b0;
        chk("fl_pre_total", o_total, 10);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        chk("fl_total", o_total, 0);
        chk("fl_open_idx", o_open_idx, 0);
        chk("fl_opened", o_opened, 0);
        chk("fl_ridx", o_retire_idx, 0);
        chk("fl_rv", o_retire_valid, 0);
        chk("fl_err", o_err, 1);

        // asynchronous reset mid-sequence
        i_open_valid = 1'b1;
        repeat (3) tick();
        i_open_valid = 1'b0;
        chk("mr_pre_total", o_total, 3);
        i_rst = 1'b1;
        #1;
        chk("mr_total", o_total, 0);
        chk("mr_opened", o_opened, 0);
        chk("mr_open_idx", o_open_idx, 0);
        chk("mr_err", o_err, 0);
        chk("mr_ready", o_open_ready, 1);
        chk("mr_rv", o_retire_valid, 0);
        i_rst = 1'b0;
        tick();
        chk("mr_post_total", o_total, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
